// File: rtl/fpu_bus_slave.sv
// Host-bus responder for the FPU core: synchronises the 8-bit host bus,
// collects operands and the operation code, launches the core, captures the
// result, and runs the cmd_end/end_ack completion handshake.
module fpu_bus_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int OP_W        = 4
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            cs,
  input  logic            rd,
  input  logic            wr,
  input  logic [3:0]      addr,
  input  logic [7:0]      databus_in,
  output logic [7:0]      databus_out,
  input  logic            end_ack,
  output logic            cmd_end,
  output logic            busy,
  output logic [31:0]     operand_a,
  output logic [31:0]     operand_b,
  output logic [OP_W-1:0] operation,
  output logic            start,
  input  logic            core_done,
  input  logic [31:0]     core_result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  // Strobes reset to their inactive level so no phantom access follows reset.
  logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync, ack_sync;
  logic [3:0]             addr_sync [SYNC_STAGES];
  logic [7:0]             data_sync [SYNC_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      // One synchroniser stage; addr/data travel alongside the strobes.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          cs_sync[gi]   <= 1'b1;
          rd_sync[gi]   <= 1'b1;
          wr_sync[gi]   <= 1'b1;
          ack_sync[gi]  <= 1'b0;
          addr_sync[gi] <= 4'h0;
          data_sync[gi] <= 8'h00;
        end else if (gi == 0) begin
          cs_sync[gi]   <= cs;
          rd_sync[gi]   <= rd;
          wr_sync[gi]   <= wr;
          ack_sync[gi]  <= end_ack;
          addr_sync[gi] <= addr;
          data_sync[gi] <= databus_in;
        end else begin
          cs_sync[gi]   <= cs_sync[gi-1];
          rd_sync[gi]   <= rd_sync[gi-1];
          wr_sync[gi]   <= wr_sync[gi-1];
          ack_sync[gi]  <= ack_sync[gi-1];
          addr_sync[gi] <= addr_sync[gi-1];
          data_sync[gi] <= data_sync[gi-1];
        end
      end
    end
  endgenerate

  logic       cs_s, rd_s, wr_s, ack_s;
  logic [3:0] addr_s;
  logic [7:0] data_s;
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign rd_s   = rd_sync[SYNC_STAGES-1];
  assign wr_s   = wr_sync[SYNC_STAGES-1];
  assign ack_s  = ack_sync[SYNC_STAGES-1];
  assign addr_s = addr_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Bus values seen during the last cycle wr was low; used at the rising edge.
  logic       wr_prev, cs_hold;
  logic [3:0] addr_hold;
  logic [7:0] data_hold;
  logic       commit, launch, idle, err, core_fire;
  logic [31:0] result;

  // Track the previous wr level and hold the strobe's address/data/select.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_prev   <= 1'b1;
      cs_hold   <= 1'b1;
      addr_hold <= 4'h0;
      data_hold <= 8'h00;
    end else begin
      wr_prev <= wr_s;
      if (!wr_s) begin
        cs_hold   <= cs_s;
        addr_hold <= addr_s;
        data_hold <= data_s;
      end
    end
  end

  assign idle      = (state == IDLE);
  assign commit    = !wr_prev && wr_s && !cs_hold;
  assign launch    = commit && idle && (addr_hold == 4'd8);
  assign core_fire = core_done && (state == RUN);

  // Register file: operands, operation, error flag, result capture, launch pulse.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      operand_a <= 32'h0;
      operand_b <= 32'h0;
      operation <= '0;
      err       <= 1'b0;
      result    <= 32'h0;
      start     <= 1'b0;
    end else begin
      start <= launch;
      if (core_fire) result <= core_result;
      if (commit && addr_hold <= 4'd8) begin
        if (!idle) begin
          err <= 1'b1;
        end else if (addr_hold == 4'd8) begin
          operation <= data_hold[OP_W-1:0];
          err       <= 1'b0;
        end else if (!addr_hold[2]) begin
          operand_a[{addr_hold[1:0], 3'b000} +: 8] <= data_hold;
        end else begin
          operand_b[{addr_hold[1:0], 3'b000} +: 8] <= data_hold;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_next;
  end

  // FSM next state: launch, core completion, host acknowledge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch)    state_next = RUN;
      RUN:     if (core_done) state_next = DONE;
      DONE:    if (ack_s)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state == RUN);
  assign cmd_end = (state == DONE);

  // Read mux on the synchronised address.
  logic [7:0] rd_mux;
  always_comb begin
    rd_mux = 8'h00;
    case (addr_s)
      4'h0, 4'h1, 4'h2, 4'h3: rd_mux = operand_a[{addr_s[1:0], 3'b000} +: 8];
      4'h4, 4'h5, 4'h6, 4'h7: rd_mux = operand_b[{addr_s[1:0], 3'b000} +: 8];
      4'h8:                   rd_mux = 8'(operation);
      4'h9:                   rd_mux = result[7:0];
      4'hA:                   rd_mux = result[15:8];
      4'hB:                   rd_mux = result[23:16];
      4'hC:                   rd_mux = result[31:24];
      4'hD:                   rd_mux = {5'b0, err, cmd_end, busy};
      default:                rd_mux = 8'h00;
    endcase
  end

  // Registered read data, driven only while the host is reading.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)             databus_out <= 8'h00;
    else if (!cs_s && !rd_s) databus_out <= rd_mux;
    else                     databus_out <= 8'h00;
  end

endmodule

// File: tb/tb_fpu_bus_slave.sv
// Directed bench for fpu_bus_slave: host-bus writes/reads, core handshake,
// error flag, ignored strobes and mid-run reset.
module tb_fpu_bus_slave;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cs = 1'b1, rd = 1'b1, wr = 1'b1;
  logic [3:0]  addr = 4'h0;
  logic [7:0]  databus_in = 8'h00;
  logic [7:0]  databus_out;
  logic        end_ack = 1'b0;
  logic        cmd_end, busy, start;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  operation;
  logic        core_done = 1'b0;
  logic [31:0] core_result = 32'h0;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int start_wide = 0;
  logic start_prev = 1'b0;
  logic [7:0] rdata;

  fpu_bus_slave #(.SYNC_STAGES(2), .OP_W(4)) dut (
    .clk(clk), .arst_n(arst_n), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .databus_in(databus_in), .databus_out(databus_out), .end_ack(end_ack),
    .cmd_end(cmd_end), .busy(busy), .operand_a(operand_a), .operand_b(operand_b),
    .operation(operation), .start(start), .core_done(core_done),
    .core_result(core_result)
  );

  always #5 clk = ~clk;

  // Count start pulses and flag any pulse longer than one cycle.
  always @(negedge clk) begin
    if (start) start_cnt++;
    if (start && start_prev) start_wide++;
    start_prev = start;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d, input logic cs_level);
    @(negedge clk);
    addr = a; databus_in = d; cs = cs_level;
    @(negedge clk); wr = 1'b0;
    repeat (3) @(negedge clk);
    wr = 1'b1;
    @(negedge clk); cs = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; cs = 1'b0; rd = 1'b0;
    repeat (5) @(negedge clk);
    d = databus_out;
    rd = 1'b1; cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic write_word(input logic [3:0] base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) bus_write(base + 4'(i), w[8*i +: 8], 1'b0);
  endtask

  task automatic pulse_done(input logic [31:0] r);
    @(negedge clk);
    core_done = 1'b1; core_result = r;
    @(negedge clk);
    core_done = 1'b0; core_result = 32'hdeadbeef;
    @(negedge clk);
  endtask

  task automatic ack_cycle();
    @(negedge clk); end_ack = 1'b1;
    repeat (4) @(negedge clk);
    end_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cmd_end", cmd_end, 0);
    check("rst_start", start, 0);
    check("rst_dout", databus_out, 8'h00);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Load operands and launch op 1.
    write_word(4'h0, 32'hc4897c85);
    write_word(4'h4, 32'hc4897c85);
    check("opa", operand_a, 32'hc4897c85);
    check("opb", operand_b, 32'hc4897c85);
    check("start_none_yet", start_cnt, 0);
    bus_write(4'h8, 8'h01, 1'b0);
    check("start_cnt1", start_cnt, 1);
    check("busy_run", busy, 1);
    check("operation", operation, 4'h1);
    bus_read(4'hD, rdata);
    check("status_run", rdata, 8'h01);
    bus_read(4'h0, rdata);
    check("read_a0", rdata, 8'h85);
    bus_read(4'h7, rdata);
    check("read_b3", rdata, 8'hc4);

    // Core completion.
    pulse_done(32'hc4c118ef);
    check("cmd_end_set", cmd_end, 1);
    check("busy_clr", busy, 0);
    bus_read(4'h9, rdata); check("res0", rdata, 8'hef);
    bus_read(4'hA, rdata); check("res1", rdata, 8'h18);
    bus_read(4'hB, rdata); check("res2", rdata, 8'hc1);
    bus_read(4'hC, rdata); check("res3", rdata, 8'hc4);
    bus_read(4'hD, rdata); check("status_done", rdata, 8'h02);
    ack_cycle();
    check("cmd_end_clr", cmd_end, 0);
    bus_read(4'hD, rdata); check("status_idle", rdata, 8'h00);
    check("idle_dout", databus_out, 8'h00);

    // Ignored strobes: cs high, addresses E/F, stray core_done in IDLE.
    bus_write(4'h0, 8'h55, 1'b1);
    bus_write(4'h8, 8'h03, 1'b1);
    bus_write(4'hE, 8'hAA, 1'b0);
    bus_write(4'hF, 8'hAA, 1'b0);
    check("cs_high_opa", operand_a, 32'hc4897c85);
    check("cs_high_nostart", start_cnt, 1);
    check("cs_high_state", busy, 0);
    bus_read(4'hE, rdata); check("read_E", rdata, 8'h00);
    bus_read(4'hF, rdata); check("read_F", rdata, 8'h00);
    pulse_done(32'h12345678);
    check("stray_done_cmd", cmd_end, 0);
    bus_read(4'h9, rdata); check("stray_done_res", rdata, 8'hef);

    // Second op; writes while busy set err and are ignored.
    bus_write(4'h8, 8'h02, 1'b0);
    check("start_cnt2", start_cnt, 2);
    check("op2", operation, 4'h2);
    bus_read(4'hC, rdata); check("old_res_kept", rdata, 8'hc4);
    bus_write(4'h0, 8'h11, 1'b0);
    bus_write(4'h8, 8'h05, 1'b0);
    check("busy_wr_opa", operand_a, 32'hc4897c85);
    check("busy_wr_op", operation, 4'h2);
    check("busy_wr_nostart", start_cnt, 2);
    bus_read(4'hD, rdata); check("status_err_busy", rdata, 8'h05);
    pulse_done(32'h3f800000);
    bus_read(4'h9, rdata); check("res2_b0", rdata, 8'h00);
    bus_read(4'hC, rdata); check("res2_b3", rdata, 8'h3f);
    bus_read(4'hD, rdata); check("status_err_done", rdata, 8'h06);
    ack_cycle();

    // Next valid launch clears err.
    bus_write(4'h8, 8'h04, 1'b0);
    check("start_cnt3", start_cnt, 3);
    bus_read(4'hD, rdata); check("status_err_clr", rdata, 8'h01);

    // Reset in the middle of RUN.
    @(negedge clk); arst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd", cmd_end, 0);
    check("mid_rst_start", start, 0);
    check("mid_rst_opa", operand_a, 0);
    check("mid_rst_opb", operand_b, 0);
    check("mid_rst_op", operation, 0);
    arst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_restart", start_cnt, 3);
    bus_read(4'hD, rdata); check("mid_rst_status", rdata, 8'h00);
    bus_read(4'h9, rdata); check("mid_rst_res", rdata, 8'h00);
    check("start_width", start_wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
